// File: rtl/button_reader.sv
// Multi-button reader: two-flop synchronizer, one debounce FSM per button,
// one-cycle press/release pulses and a wrapping count of accepted presses.
//
// state      | meaning
// IDLE_REL   | accepted released, input agrees
// WAIT_PRESS | input reads pressed, counting stable samples
// IDLE_PRESS | accepted pressed, input agrees
// WAIT_REL   | input reads released, counting stable samples
module button_reader #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [7:0]       press_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_BTN-1:0] REL_RAW = {N_BTN{ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE_REL, WAIT_PRESS, IDLE_PRESS, WAIT_REL} state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] w_sync;
  logic [7:0]       r_press_count;
  logic [7:0]       w_press_sum;

  // Synchronizer resets to the released pin level so no edge is seen at reset exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= REL_RAW;
      r_sync2 <= REL_RAW;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          w_level_nxt;
    logic          r_press;
    logic          w_press_nxt;
    logic          r_rel;
    logic          w_rel_nxt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= IDLE_REL;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_press <= 1'b0;
        r_rel   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_level <= w_level_nxt;
        r_press <= w_press_nxt;
        r_rel   <= w_rel_nxt;
      end
    end

    // Any sample matching the accepted level drops the count to zero.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_level_nxt = r_level;
      w_press_nxt = 1'b0;
      w_rel_nxt   = 1'b0;
      case (r_state)
        IDLE_REL: begin
          if (w_sync[g]) begin
            w_state_nxt = WAIT_PRESS;
            w_cnt_nxt   = CW'(1);
          end
        end
        WAIT_PRESS: begin
          if (!w_sync[g]) begin
            w_state_nxt = IDLE_REL;
          end else if (r_cnt == TC) begin
            w_state_nxt = IDLE_PRESS;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        IDLE_PRESS: begin
          if (!w_sync[g]) begin
            w_state_nxt = WAIT_REL;
            w_cnt_nxt   = CW'(1);
          end
        end
        WAIT_REL: begin
          if (w_sync[g]) begin
            w_state_nxt = IDLE_PRESS;
          end else if (r_cnt == TC) begin
            w_state_nxt = IDLE_REL;
            w_level_nxt = 1'b0;
            w_rel_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: w_state_nxt = IDLE_REL;
      endcase
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_rel;
  end

  always_comb begin
    w_press_sum = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_press_sum = w_press_sum + 8'(btn_press[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_press_count <= '0;
    end else begin
      r_press_count <= r_press_count + w_press_sum;
    end
  end

  assign press_count = r_press_count;

endmodule
